ahb_multiport_mem: RTL and testbench
====================================

Name: ahb_multiport_mem

Overview:
- Parametrised AHB-Lite slave memory for the zscale simulation harness.
- Serves NPORTS independent AHB-Lite masters (imem, dmem, future DMA/debug) from one shared byte-addressed array.
- Correct address/data-phase pipelining, SEQ/INCR bursts, programmable wait states, two-cycle ERROR responses.
- Memory-mapped console and test-pass registers.

Parameters:
- XLEN, 32, data/address width; 32 or 64 only.
- NPORTS, 2, number of AHB-Lite slave ports, 1..4.
- MEM_BYTES, 65536, array size in bytes; power of two.
- WAIT_MODE, 0, 0 = zero-wait, 1 = FIXED_WAIT per transfer, 2 = pseudo-random 0..3 waits per port.
- FIXED_WAIT, 2, wait cycles used when WAIT_MODE=1; 0..15.
- CONSOLE_ADDR, 32'h1000_0000, console byte register address.
- PASS_ADDR, 32'h2000_0000, test-pass register address.
- PASS_VALUE, 123456789, value that sets tests_passed.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- htrans  in  2*NPORTS  per-port HTRANS, port p at [2p+1:2p]
- haddr  in  XLEN*NPORTS  per-port HADDR
- hwrite  in  NPORTS  per-port HWRITE
- hsize  in  3*NPORTS  per-port HSIZE
- hburst  in  3*NPORTS  per-port HBURST; accepted, not decoded
- hwdata  in  XLEN*NPORTS  per-port HWDATA; valid in data phase
- hrdata  out  XLEN*NPORTS  per-port HRDATA
- hready  out  NPORTS  per-port HREADYOUT
- hresp  out  NPORTS  per-port HRESP (1 = ERROR)
- console_valid  out  1  one-cycle pulse on console write
- console_data  out  8  console byte, valid with console_valid
- tests_passed  out  1  sticky pass flag

Behaviour:
- Reset (resetn=0 at posedge clk): hready=all 1, hresp=0, hrdata=0, console_valid=0, console_data=0, tests_passed=0. All port FSMs go to IDLE and pending transfers are dropped. Array contents are preserved.
- Port FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
- Address phase is accepted when htrans[1]=1 and hready=1 at posedge. Latch addr, size, write and in-range flag.
  - In range: go to WAIT with a wait count from the wait-mode rule, or to DATA if the count is 0.
  - Out of range, or misaligned for hsize: go to ERR1.
  - Exception: CONSOLE_ADDR and PASS_ADDR are valid for writes only.
- htrans IDLE/BUSY: no transfer; next cycle hready=1, hresp=0.
- Wait-mode rule:
  - WAIT_MODE=0: count 0.
  - WAIT_MODE=1: count FIXED_WAIT.
  - WAIT_MODE=2: count = per-port 16-bit LFSR[1:0]. Seed 16'hACE1 ^ p; the LFSR advances on every accepted address phase.
- WAIT: hready=0, hresp=0; decrement count each cycle; go to DATA when it reaches 0.
- DATA, one cycle:
  - Write: sample hwdata this cycle (never in the address phase). Apply byte strobes derived from hsize and addr[log2(XLEN/8)-1:0]. Data sits on its natural byte lanes; no shifting.
  - Read: hrdata = full word at addr; the master selects lanes.
  - Drive hready=1, hresp=0.
- Zero-wait throughput: DATA overlaps the next address phase, giving back-to-back transfers at 1 per cycle.
- ERR1: hready=0, hresp=1. ERR2: hready=1, hresp=1. After ERR2, accept a new address phase (IDLE, or a direct transfer if one is presented).
- Console write: console_valid=1 for exactly one cycle in DATA; console_data = hwdata[7:0].
- PASS_ADDR write: tests_passed=1 if hwdata[31:0]==PASS_VALUE. Otherwise no change.
- Same-cycle multi-port writes to the same byte: highest port index wins.
- Same-cycle read and write to the same word: the read returns the pre-write value.
- 64-bit mode: memory word index = addr>>3; 32-bit mode: addr>>2.
- Reset asserted mid-WAIT or mid-ERR1: the transfer is abandoned with no array write, and the next cycle's outputs are the reset values.

Decomposition:
- Package ahb_mem_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HSIZE_BYTE/HALF/WORD/DWORD
  - HRESP_OKAY/ERROR
  - port FSM state enum
  - strobe-generation function strb(hsize, addr_lsbs)
- One sub-module, ahb_mem_port, instantiated NPORTS times. It contains the FSM, wait counter, LFSR and latched address-phase state. It outputs a write request (word index, strobes, data), a read index, and console/pass strobes.
- The top level owns the array, port-ordered write merge, console/pass logic and the read muxing.

Test Plan:
- WAIT_MODE=0, port 0: write 32'hDEADBEEF to 0x100, then read 0x100 -> hrdata=DEADBEEF. hready never low. Back-to-back NONSEQ+SEQ to 0x100/0x104 complete in consecutive cycles.
- Byte write hsize=0, addr 0x103, hwdata=32'hAA000000 over 0x11223344 -> read 0xAA223344. XLEN=64 dword write at 0x8 reads back intact.
- Read 0x0002_0000 (out of range) -> cycle 1: hready=0, hresp=1; cycle 2: hready=1, hresp=1. Array is unchanged.
- WAIT_MODE=1, FIXED_WAIT=3: single read -> hready low exactly 3 cycles, then data. Assert resetn=0 during the 2nd wait cycle -> next cycle hready=1, hresp=0, and no write occurs.
- Write 0x41 to CONSOLE_ADDR -> one-cycle console_valid with console_data=8'h41. Write 123456789 to PASS_ADDR -> tests_passed=1 and stays 1. Writing 5 instead leaves it 0.
- Ports 0 and 1 write 0x11 and 0x22 to byte 0x200 in the same cycle -> read returns 0x22. Port 0 reads 0x200 while port 1 writes it -> port 0 gets the old value.

Source files
------------

// File: rtl/ahb_multiport_mem_pkg.sv
// Shared AHB-Lite encodings, port FSM states and the byte-strobe helper
// for the multi-port simulation memory.
package ahb_mem_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} port_state_e;
    typedef enum logic [1:0] {TGT_MEM, TGT_CONSOLE, TGT_PASS} tgt_e;

    // Lane enables for a naturally aligned transfer of 2**hsize bytes.
    function automatic logic [7:0] strb(input logic [2:0] hsize, input logic [2:0] addr_lsbs);
        logic [8:0] ones;
        ones = (9'd1 << (4'd1 << hsize[1:0])) - 9'd1;
        return ones[7:0] << addr_lsbs;
    endfunction

endpackage

// File: rtl/ahb_multiport_mem_if.sv
// Bundle of NPORTS AHB-Lite slave ports, flattened per signal with port p
// occupying slice p of each vector.
interface ahb_multiport_mem_if #(
    parameter int XLEN   = 32,
    parameter int NPORTS = 2
);
    logic [2*NPORTS-1:0]    htrans;
    logic [XLEN*NPORTS-1:0] haddr;
    logic [NPORTS-1:0]      hwrite;
    logic [3*NPORTS-1:0]    hsize;
    logic [3*NPORTS-1:0]    hburst;
    logic [XLEN*NPORTS-1:0] hwdata;
    logic [XLEN*NPORTS-1:0] hrdata;
    logic [NPORTS-1:0]      hready;
    logic [NPORTS-1:0]      hresp;

    modport master (output htrans, haddr, hwrite, hsize, hburst, hwdata,
                    input  hrdata, hready, hresp);
    modport slave  (input  htrans, haddr, hwrite, hsize, hburst, hwdata,
                    output hrdata, hready, hresp);
endinterface

// File: rtl/ahb_multiport_mem_port.sv
// One AHB-Lite slave port: address-phase decode, wait/error FSM and the
// request it presents to the shared array during its data phase.
module ahb_mem_port
    import ahb_mem_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              MEM_BYTES    = 65536,
    parameter int              WAIT_MODE    = 0,
    parameter int              FIXED_WAIT   = 2,
    parameter int              PORT_IDX     = 0,
    parameter int              IDX_W        = 14,
    parameter logic [XLEN-1:0] CONSOLE_ADDR = 'h1000_0000,
    parameter logic [XLEN-1:0] PASS_ADDR    = 'h2000_0000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [1:0]        htrans_i,
    input  logic [XLEN-1:0]   haddr_i,
    input  logic              hwrite_i,
    input  logic [2:0]        hsize_i,
    input  logic [XLEN-1:0]   hwdata_i,
    output logic              hready_o,
    output logic              hresp_o,
    output logic              we_o,
    output logic              re_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic [XLEN/8-1:0] strb_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic              console_we_o,
    output logic              pass_we_o
);
    localparam int BL = $clog2(XLEN/8);
    localparam int SW = XLEN/8;

    port_state_e      state_q;
    logic             hready_q, hresp_q, wr_q;
    logic [3:0]       cnt_q, wait_d;
    logic [15:0]      lfsr_q;
    logic [IDX_W-1:0] idx_q;
    logic [2:0]       lsb_q, lsb_d, size_q;
    tgt_e             tgt_q, tgt_d;
    logic             accept, ok_d, in_data;

    assign accept = htrans_i[1] & hready_q;

    always_comb begin
        lsb_d = '0;
        lsb_d[BL-1:0] = haddr_i[BL-1:0];
        tgt_d = TGT_MEM;
        if (haddr_i == CONSOLE_ADDR)   tgt_d = TGT_CONSOLE;
        else if (haddr_i == PASS_ADDR) tgt_d = TGT_PASS;
        // Register targets only accept writes; memory must lie inside the array.
        ok_d = (hsize_i <= 3'(BL))
            && ((lsb_d & ((3'd1 << hsize_i[1:0]) - 3'd1)) == 3'd0)
            && ((tgt_d == TGT_MEM) ? (haddr_i < XLEN'(MEM_BYTES)) : hwrite_i);
        if (WAIT_MODE == 1)      wait_d = 4'(FIXED_WAIT);
        else if (WAIT_MODE == 2) wait_d = {2'b00, lfsr_q[1:0]};
        else                     wait_d = 4'd0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            cnt_q    <= 4'd0;
            lfsr_q   <= 16'hACE1 ^ 16'(PORT_IDX);
        end else begin
            if (accept)
                lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            case (state_q)
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q  <= ST_DATA;
                        hready_q <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state_q  <= ST_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_ERROR;
                end
                default: begin
                    // IDLE, DATA and ERR2 all show hready=1, so a new address phase may land here.
                    state_q  <= ST_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_OKAY;
                    if (accept) begin
                        if (!ok_d) begin
                            state_q  <= ST_ERR1;
                            hready_q <= 1'b0;
                            hresp_q  <= HRESP_ERROR;
                        end else if (wait_d == 4'd0) begin
                            state_q <= ST_DATA;
                        end else begin
                            state_q  <= ST_WAIT;
                            hready_q <= 1'b0;
                            cnt_q    <= wait_d;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q  <= haddr_i[BL +: IDX_W];
            lsb_q  <= lsb_d;
            size_q <= hsize_i;
            wr_q   <= hwrite_i;
            tgt_q  <= tgt_d;
        end
    end

    assign in_data      = (state_q == ST_DATA);
    assign hready_o     = hready_q;
    assign hresp_o      = hresp_q;
    assign we_o         = in_data & wr_q & (tgt_q == TGT_MEM);
    assign re_o         = in_data & ~wr_q;
    assign idx_o        = idx_q;
    assign strb_o       = SW'(strb(size_q, lsb_q));
    assign wdata_o      = hwdata_i;
    assign console_we_o = in_data & wr_q & (tgt_q == TGT_CONSOLE);
    assign pass_we_o    = in_data & wr_q & (tgt_q == TGT_PASS);

endmodule

// File: rtl/ahb_multiport_mem.sv
// Shared byte-addressed simulation memory behind NPORTS AHB-Lite slave ports,
// with a console byte register and a sticky test-pass flag.
module ahb_multiport_mem
    import ahb_mem_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              NPORTS       = 2,
    parameter int              MEM_BYTES    = 65536,
    parameter int              WAIT_MODE    = 0,
    parameter int              FIXED_WAIT   = 2,
    parameter logic [XLEN-1:0] CONSOLE_ADDR = 'h1000_0000,
    parameter logic [XLEN-1:0] PASS_ADDR    = 'h2000_0000,
    parameter logic [31:0]     PASS_VALUE   = 32'd123456789
) (
    input  logic                      clk,
    input  logic                      resetn,
    ahb_multiport_mem_if.slave        bus,
    output logic                      console_valid,
    output logic [7:0]                console_data,
    output logic                      tests_passed
);
    localparam int SW    = XLEN/8;
    localparam int BL    = $clog2(SW);
    localparam int IDX_W = $clog2(MEM_BYTES) - BL;
    localparam int DEPTH = MEM_BYTES / SW;

    logic [XLEN-1:0]        mem_q [DEPTH];
    logic [NPORTS-1:0]      we, re, con_we, pass_we, hready_w, hresp_w;
    logic [IDX_W-1:0]       idx   [NPORTS];
    logic [SW-1:0]          wstrb [NPORTS];
    logic [XLEN-1:0]        wdata [NPORTS];
    logic [XLEN*NPORTS-1:0] hrdata_w;
    logic                   tests_passed_q;
    logic                   unused_hburst;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        ahb_mem_port #(
            .XLEN(XLEN), .MEM_BYTES(MEM_BYTES), .WAIT_MODE(WAIT_MODE),
            .FIXED_WAIT(FIXED_WAIT), .PORT_IDX(p), .IDX_W(IDX_W),
            .CONSOLE_ADDR(CONSOLE_ADDR), .PASS_ADDR(PASS_ADDR)
        ) u_port (
            .clk          (clk),
            .resetn       (resetn),
            .htrans_i     (bus.htrans[2*p +: 2]),
            .haddr_i      (bus.haddr[XLEN*p +: XLEN]),
            .hwrite_i     (bus.hwrite[p]),
            .hsize_i      (bus.hsize[3*p +: 3]),
            .hwdata_i     (bus.hwdata[XLEN*p +: XLEN]),
            .hready_o     (hready_w[p]),
            .hresp_o      (hresp_w[p]),
            .we_o         (we[p]),
            .re_o         (re[p]),
            .idx_o        (idx[p]),
            .strb_o       (wstrb[p]),
            .wdata_o      (wdata[p]),
            .console_we_o (con_we[p]),
            .pass_we_o    (pass_we[p])
        );
    end

    assign bus.hready    = hready_w;
    assign bus.hresp     = hresp_w;
    assign bus.hrdata    = hrdata_w;
    assign unused_hburst = ^bus.hburst;

    // Combinational read sees the array before this edge's writes land.
    always_comb begin
        hrdata_w = '0;
        for (int p = 0; p < NPORTS; p++)
            if (re[p]) hrdata_w[XLEN*p +: XLEN] = mem_q[idx[p]];
    end

    // Ascending port order: the last non-blocking update to a byte wins.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++)
            if (resetn && we[p])
                for (int b = 0; b < SW; b++)
                    if (wstrb[p][b]) mem_q[idx[p]][8*b +: 8] <= wdata[p][8*b +: 8];
    end

    always_comb begin
        console_valid = 1'b0;
        console_data  = 8'h00;
        for (int p = 0; p < NPORTS; p++)
            if (resetn && con_we[p]) begin
                console_valid = 1'b1;
                console_data  = wdata[p][7:0];
            end
    end

    always_ff @(posedge clk) begin
        if (!resetn) tests_passed_q <= 1'b0;
        else
            for (int p = 0; p < NPORTS; p++)
                if (pass_we[p] && wdata[p][31:0] == PASS_VALUE) tests_passed_q <= 1'b1;
    end

    assign tests_passed = tests_passed_q;

endmodule

// File: tb/tb_ahb_multiport_mem.sv
// Directed bench: zero-wait 2-port, fixed-wait 2-port and 64-bit 1-port memories.
module tb_ahb_multiport_mem;
    import ahb_mem_pkg::*;

    localparam logic [31:0] CON  = 32'h1000_0000;
    localparam logic [31:0] PASS = 32'h2000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn_a, rstn_b;
    int   ncmp = 0;
    int   nfail = 0;

    ahb_multiport_mem_if #(.XLEN(32), .NPORTS(2)) ifa ();
    ahb_multiport_mem_if #(.XLEN(32), .NPORTS(2)) ifb ();
    ahb_multiport_mem_if #(.XLEN(64), .NPORTS(1)) ifc ();

    logic       cv_a, cv_b, cv_c, tp_a, tp_b, tp_c;
    logic [7:0] cd_a, cd_b, cd_c;

    ahb_multiport_mem #(.XLEN(32), .NPORTS(2), .WAIT_MODE(0)) dut_a (
        .clk(clk), .resetn(rstn_a), .bus(ifa),
        .console_valid(cv_a), .console_data(cd_a), .tests_passed(tp_a));
    ahb_multiport_mem #(.XLEN(32), .NPORTS(2), .WAIT_MODE(1), .FIXED_WAIT(3)) dut_b (
        .clk(clk), .resetn(rstn_b), .bus(ifb),
        .console_valid(cv_b), .console_data(cd_b), .tests_passed(tp_b));
    ahb_multiport_mem #(.XLEN(64), .NPORTS(1), .WAIT_MODE(0)) dut_c (
        .clk(clk), .resetn(rstn_a), .bus(ifc),
        .console_valid(cv_c), .console_data(cd_c), .tests_passed(tp_c));

    // Index 0 drives dut_a, index 1 drives dut_b.
    logic [3:0]  htrans_v [2];
    logic [63:0] haddr_v  [2];
    logic [1:0]  hwrite_v [2];
    logic [5:0]  hsize_v  [2];
    logic [63:0] hwdata_v [2];
    logic [63:0] hrdata_v [2];
    logic [1:0]  hready_v [2];
    logic [1:0]  hresp_v  [2];

    assign ifa.htrans = htrans_v[0];  assign ifb.htrans = htrans_v[1];
    assign ifa.haddr  = haddr_v[0];   assign ifb.haddr  = haddr_v[1];
    assign ifa.hwrite = hwrite_v[0];  assign ifb.hwrite = hwrite_v[1];
    assign ifa.hsize  = hsize_v[0];   assign ifb.hsize  = hsize_v[1];
    assign ifa.hwdata = hwdata_v[0];  assign ifb.hwdata = hwdata_v[1];
    assign ifa.hburst = '0;           assign ifb.hburst = '0;
    assign hrdata_v[0] = ifa.hrdata;  assign hrdata_v[1] = ifb.hrdata;
    assign hready_v[0] = ifa.hready;  assign hready_v[1] = ifb.hready;
    assign hresp_v[0]  = ifa.hresp;   assign hresp_v[1]  = ifb.hresp;

    typedef struct {
        int          p;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // One single transfer; returns data, hresp of the first post-accept cycle,
    // hresp at completion, and the number of cycles hready was low.
    task automatic xfer(input int d, input int p, input logic wr, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic r0, output logic r1, output int waits);
        @(negedge clk);
        htrans_v[d][2*p +: 2] = HTRANS_NONSEQ;
        haddr_v[d][32*p +: 32] = addr;
        hwrite_v[d][p] = wr;
        hsize_v[d][3*p +: 3] = sz;
        @(negedge clk);
        htrans_v[d][2*p +: 2] = HTRANS_IDLE;
        hwdata_v[d][32*p +: 32] = wd;
        #1;
        r0 = hresp_v[d][p];
        waits = 0;
        while (!hready_v[d][p] && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        rd = hrdata_v[d][32*p +: 32];
        r1 = hresp_v[d][p];
    endtask

    task automatic xfer_c(input logic wr, input logic [2:0] sz, input logic [63:0] addr,
                          input logic [63:0] wd, output logic [63:0] rd, output int waits);
        @(negedge clk);
        ifc.htrans = HTRANS_NONSEQ; ifc.haddr = addr; ifc.hwrite = wr; ifc.hsize = sz;
        @(negedge clk);
        ifc.htrans = HTRANS_IDLE; ifc.hwdata = wd;
        waits = 0;
        while (!ifc.hready[0] && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        rd = ifc.hrdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [63:0] rd64;
        logic        r0, r1;
        int          w;

        for (int d = 0; d < 2; d++) begin
            htrans_v[d] = '0; haddr_v[d] = '0; hwrite_v[d] = '0; hsize_v[d] = '0; hwdata_v[d] = '0;
        end
        ifc.htrans = '0; ifc.haddr = '0; ifc.hwrite = '0; ifc.hsize = '0;
        ifc.hwdata = '0; ifc.hburst = '0;
        rstn_a = 1'b0; rstn_b = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_hready_a", 64'(hready_v[0]), 64'h3);
        chk("rst_hresp_a",  64'(hresp_v[0]),  64'h0);
        chk("rst_hrdata_a", hrdata_v[0],      64'h0);
        chk("rst_cvalid_a", 64'(cv_a),        64'h0);
        chk("rst_cdata_a",  64'(cd_a),        64'h0);
        chk("rst_passed_a", 64'(tp_a),        64'h0);
        chk("rst_hready_b", 64'(hready_v[1]), 64'h3);
        chk("rst_hready_c", 64'(ifc.hready),  64'h1);
        rstn_a = 1'b1; rstn_b = 1'b1;

        vecs.push_back('{0, 1'b1, HSIZE_WORD, 32'h0000_0000, 32'h0BAD_F00D, 32'h0,         1'b0});
        vecs.push_back('{0, 1'b1, HSIZE_WORD, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         1'b0});
        vecs.push_back('{0, 1'b0, HSIZE_WORD, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{0, 1'b1, HSIZE_WORD, 32'h0000_0300, 32'h1122_3344, 32'h0,         1'b0});
        vecs.push_back('{0, 1'b1, HSIZE_BYTE, 32'h0000_0303, 32'hAA00_0000, 32'h0,         1'b0});
        vecs.push_back('{0, 1'b0, HSIZE_WORD, 32'h0000_0300, 32'h0,         32'hAA22_3344, 1'b0});
        vecs.push_back('{0, 1'b1, HSIZE_HALF, 32'h0000_0300, 32'h0000_BEEF, 32'h0,         1'b0});
        vecs.push_back('{0, 1'b0, HSIZE_BYTE, 32'h0000_0301, 32'h0,         32'hAA22_BEEF, 1'b0});
        vecs.push_back('{0, 1'b0, HSIZE_WORD, 32'h0002_0000, 32'h0,         32'h0,         1'b1});
        vecs.push_back('{0, 1'b1, HSIZE_WORD, 32'h0002_0000, 32'hDDDD_DDDD, 32'h0,         1'b1});
        vecs.push_back('{0, 1'b0, HSIZE_WORD, 32'h0000_0000, 32'h0,         32'h0BAD_F00D, 1'b0});
        vecs.push_back('{0, 1'b0, HSIZE_WORD, 32'h0000_0102, 32'h0,         32'h0,         1'b1});
        vecs.push_back('{0, 1'b1, HSIZE_HALF, 32'h0000_0101, 32'h1234_5678, 32'h0,         1'b1});
        vecs.push_back('{0, 1'b0, HSIZE_WORD, CON,           32'h0,         32'h0,         1'b1});
        vecs.push_back('{0, 1'b0, HSIZE_WORD, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1, 1'b1, HSIZE_WORD, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,         1'b0});
        vecs.push_back('{0, 1'b0, HSIZE_WORD, 32'h0000_0400, 32'h0,         32'hCAFE_F00D, 1'b0});
        vecs.push_back('{1, 1'b0, HSIZE_HALF, 32'h0000_0300, 32'h0,         32'hAA22_BEEF, 1'b0});

        foreach (vecs[i]) begin
            xfer(0, vecs[i].p, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wd, rd, r0, r1, w);
            chk($sformatf("v%0d_resp_first", i), 64'(r0), 64'(vecs[i].exp_err));
            chk($sformatf("v%0d_resp_last", i),  64'(r1), 64'(vecs[i].exp_err));
            chk($sformatf("v%0d_wait", i),       64'(w),  vecs[i].exp_err ? 64'd1 : 64'd0);
            if (!vecs[i].wr && !vecs[i].exp_err)
                chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
        end

        // NONSEQ+SEQ write burst then read burst, one transfer per cycle.
        @(negedge clk);
        htrans_v[0][1:0] = HTRANS_NONSEQ; haddr_v[0][31:0] = 32'h100; hwrite_v[0][0] = 1'b1; hsize_v[0][2:0] = HSIZE_WORD;
        @(negedge clk);
        chk("burst_w0_ready", 64'(hready_v[0][0]), 64'h1);
        htrans_v[0][1:0] = HTRANS_SEQ; haddr_v[0][31:0] = 32'h104; hwdata_v[0][31:0] = 32'h1111_1111;
        @(negedge clk);
        chk("burst_w1_ready", 64'(hready_v[0][0]), 64'h1);
        htrans_v[0][1:0] = HTRANS_IDLE; hwdata_v[0][31:0] = 32'h2222_2222;
        @(negedge clk);
        htrans_v[0][1:0] = HTRANS_NONSEQ; haddr_v[0][31:0] = 32'h100; hwrite_v[0][0] = 1'b0;
        @(negedge clk);
        chk("burst_r0_ready", 64'(hready_v[0][0]), 64'h1);
        chk("burst_r0_data",  64'(hrdata_v[0][31:0]), 64'h1111_1111);
        htrans_v[0][1:0] = HTRANS_SEQ; haddr_v[0][31:0] = 32'h104;
        @(negedge clk);
        chk("burst_r1_ready", 64'(hready_v[0][0]), 64'h1);
        chk("burst_r1_data",  64'(hrdata_v[0][31:0]), 64'h2222_2222);
        htrans_v[0][1:0] = HTRANS_IDLE;

        // Console pulse.
        @(negedge clk);
        htrans_v[0][1:0] = HTRANS_NONSEQ; haddr_v[0][31:0] = CON; hwrite_v[0][0] = 1'b1; hsize_v[0][2:0] = HSIZE_BYTE;
        #1;
        chk("con_before", 64'(cv_a), 64'h0);
        @(negedge clk);
        htrans_v[0][1:0] = HTRANS_IDLE; hwdata_v[0][31:0] = 32'h0000_0041;
        #1;
        chk("con_valid", 64'(cv_a), 64'h1);
        chk("con_data",  64'(cd_a), 64'h41);
        @(negedge clk);
        #1;
        chk("con_after", 64'(cv_a), 64'h0);

        // Pass register.
        xfer(0, 0, 1'b1, HSIZE_WORD, PASS, 32'd5, rd, r0, r1, w);
        @(negedge clk);
        chk("pass_wrong_value", 64'(tp_a), 64'h0);
        xfer(0, 0, 1'b1, HSIZE_WORD, PASS, 32'd123456789, rd, r0, r1, w);
        @(negedge clk);
        chk("pass_set", 64'(tp_a), 64'h1);
        xfer(0, 0, 1'b1, HSIZE_WORD, PASS, 32'd5, rd, r0, r1, w);
        @(negedge clk);
        chk("pass_sticky", 64'(tp_a), 64'h1);

        // Both ports write the same byte in the same cycle.
        xfer(0, 0, 1'b1, HSIZE_WORD, 32'h200, 32'h0, rd, r0, r1, w);
        @(negedge clk);
        htrans_v[0] = {HTRANS_NONSEQ, HTRANS_NONSEQ};
        haddr_v[0] = {32'h200, 32'h200}; hwrite_v[0] = 2'b11; hsize_v[0] = {HSIZE_BYTE, HSIZE_BYTE};
        @(negedge clk);
        htrans_v[0] = '0; hwdata_v[0] = {32'h0000_0022, 32'h0000_0011};
        xfer(0, 0, 1'b0, HSIZE_WORD, 32'h200, 32'h0, rd, r0, r1, w);
        chk("mp_write_prio", 64'(rd), 64'h0000_0022);

        // Port 0 reads while port 1 writes the same word.
        @(negedge clk);
        htrans_v[0] = {HTRANS_NONSEQ, HTRANS_NONSEQ};
        haddr_v[0] = {32'h200, 32'h200}; hwrite_v[0] = 2'b10; hsize_v[0] = {HSIZE_WORD, HSIZE_WORD};
        @(negedge clk);
        htrans_v[0] = '0; hwdata_v[0] = {32'h9999_9999, 32'h0};
        #1;
        chk("rw_old_value", 64'(hrdata_v[0][31:0]), 64'h0000_0022);
        hwrite_v[0] = 2'b00;
        xfer(0, 0, 1'b0, HSIZE_WORD, 32'h200, 32'h0, rd, r0, r1, w);
        chk("rw_new_value", 64'(rd), 64'h9999_9999);

        // Fixed three-cycle wait states.
        xfer(1, 0, 1'b1, HSIZE_WORD, 32'h100, 32'h1234_5678, rd, r0, r1, w);
        chk("fw_write_waits", 64'(w), 64'd3);
        xfer(1, 0, 1'b0, HSIZE_WORD, 32'h100, 32'h0, rd, r0, r1, w);
        chk("fw_read_waits", 64'(w),  64'd3);
        chk("fw_read_data",  64'(rd), 64'h1234_5678);
        chk("fw_read_resp",  64'(r1), 64'h0);

        // Reset during the second wait cycle abandons the write.
        @(negedge clk);
        htrans_v[1][1:0] = HTRANS_NONSEQ; haddr_v[1][31:0] = 32'h100; hwrite_v[1][0] = 1'b1; hsize_v[1][2:0] = HSIZE_WORD;
        @(negedge clk);
        htrans_v[1][1:0] = HTRANS_IDLE; hwdata_v[1][31:0] = 32'hFFFF_FFFF;
        chk("rw_wait1_low", 64'(hready_v[1][0]), 64'h0);
        @(negedge clk);
        chk("rw_wait2_low", 64'(hready_v[1][0]), 64'h0);
        rstn_b = 1'b0;
        @(negedge clk);
        chk("rst_wait_hready", 64'(hready_v[1]), 64'h3);
        chk("rst_wait_hresp",  64'(hresp_v[1]),  64'h0);
        rstn_b = 1'b1;
        xfer(1, 0, 1'b0, HSIZE_WORD, 32'h100, 32'h0, rd, r0, r1, w);
        chk("rst_wait_nowrite", 64'(rd), 64'h1234_5678);

        // Reset during ERR1.
        @(negedge clk);
        htrans_v[1][1:0] = HTRANS_NONSEQ; haddr_v[1][31:0] = 32'h0002_0000; hwrite_v[1][0] = 1'b0;
        @(negedge clk);
        htrans_v[1][1:0] = HTRANS_IDLE;
        chk("err1_hresp", 64'(hresp_v[1][0]), 64'h1);
        rstn_b = 1'b0;
        @(negedge clk);
        chk("rst_err_hready", 64'(hready_v[1]), 64'h3);
        chk("rst_err_hresp",  64'(hresp_v[1]),  64'h0);
        rstn_b = 1'b1;

        // 64-bit data path.
        xfer_c(1'b1, HSIZE_DWORD, 64'h8, 64'h0123_4567_89AB_CDEF, rd64, w);
        chk("x64_write_waits", 64'(w), 64'd0);
        xfer_c(1'b0, HSIZE_DWORD, 64'h8, 64'h0, rd64, w);
        chk("x64_dword", rd64, 64'h0123_4567_89AB_CDEF);
        xfer_c(1'b1, HSIZE_BYTE, 64'hD, 64'h0000_5A00_0000_0000, rd64, w);
        xfer_c(1'b0, HSIZE_WORD, 64'hC, 64'h0, rd64, w);
        chk("x64_byte_lane", rd64, 64'h0123_5A67_89AB_CDEF);
        xfer_c(1'b0, HSIZE_DWORD, 64'h4, 64'h0, rd64, w);
        chk("x64_misaligned_err", 64'(ifc.hresp), 64'h1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
